// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage: register file, control/ALU decode, immediate generation, ID/EX register
module decode_cycle #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [XLEN-1:0] rf [NREG];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  logic            reg_write, alu_src, mem_write, branch, jump;
  logic [1:0]      imm_src, result_src, alu_op;
  logic [2:0]      alu_control;
  logic [XLEN-1:0] rd1, rd2, imm_ext;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];
  assign rd     = InstrD[11:7];

  // Register file write port; x0 is never written so it always reads back zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (RegWriteW && (RdW != 5'd0)) begin
      rf[RdW] <= ResultW;
    end
  end

  // Combinational reads with write-first bypass so a same-cycle writeback is seen by decode.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != 5'd0) rd1 = (RegWriteW && (RdW == rs1)) ? ResultW : rf[rs1];
    if (rs2 != 5'd0) rd2 = (RegWriteW && (RdW == rs2)) ? ResultW : rf[rs2];
  end

  // Main decoder: unknown opcodes fall through to an all-zero NOP.
  always_comb begin
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    alu_op     = 2'b00;
    jump       = 1'b0;
    case (opcode)
      OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = 2'b01; end
      OP_SW:   begin imm_src = 2'b01; alu_src = 1'b1; mem_write = 1'b1; end
      OP_R:    begin reg_write = 1'b1; alu_op = 2'b10; end
      OP_BEQ:  begin imm_src = 2'b10; branch = 1'b1; alu_op = 2'b01; end
      OP_IALU: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      OP_JAL:  begin reg_write = 1'b1; imm_src = 2'b11; result_src = 2'b10; jump = 1'b1; end
      default: ;
    endcase
  end

  // ALU decoder: subtract only for R-type with funct7[5] set, never for addi.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (opcode[5] && InstrD[30]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Immediate generator, always sign-extended from InstrD[31].
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      2'b00: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      2'b01: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      2'b11: imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // ID/EX register: reset and flush both load an all-zero bubble, flush beating capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 2'b00;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      ALUSrcE     <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
      RdE         <= 5'd0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= reg_write;
      ResultSrcE  <= result_src;
      MemWriteE   <= mem_write;
      JumpE       <= jump;
      BranchE     <= branch;
      ALUControlE <= alu_control;
      ALUSrcE     <= alu_src;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      Rs1E        <= rs1;
      Rs2E        <= rs2;
      RdE         <= rd;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule
